// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - packs symbolic MIPS instruction requests into words and streams them into instruction memory
module instr_encoder_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
    parameter int          DEPTH     = 64,
    parameter int          CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op_sel,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic [4:0]       rd,
    input  logic [4:0]       shamt,
    input  logic [5:0]       funct,
    input  logic [15:0]      imm,
    input  logic [31:0]      target,
    output logic             imem_we,
    output logic [31:0]      imem_addr,
    output logic [31:0]      imem_wdata,
    output logic [CNT_W-1:0] word_count,
    output logic             full,
    output logic             err,
    output logic [1:0]       err_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_FULL,
        S_ERROR
    } state_t;

    state_t           state_q;
    logic [31:0]      pc_q;
    logic [CNT_W-1:0] count_q;
    logic             in_ready_q;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic             full_q;
    logic             err_q;
    logic [1:0]       err_code_q;

    logic [31:0]        wdata_d;
    logic [1:0]         code_d;
    logic [31:0]        pc_next4;
    logic signed [32:0] br_diff;
    logic signed [32:0] br_off;
    logic               br_in_range;

    // Branch offsets are resolved against the slot this word will occupy.
    assign pc_next4    = pc_q + 32'd4;
    assign br_diff     = $signed({1'b0, target}) - $signed({1'b0, pc_next4});
    assign br_off      = br_diff >>> 2;
    assign br_in_range = (br_off[32:15] == {18{br_off[15]}});

    always_comb begin
        wdata_d = 32'd0;
        code_d  = 2'd0;
        case (op_sel)
            4'd0:  wdata_d = {6'h00, rs, rt, rd, shamt, funct};
            4'd1:  wdata_d = {6'h08, rs, rt, imm};
            4'd2:  wdata_d = {6'h0d, rs, rt, imm};
            4'd3:  wdata_d = {6'h0c, rs, rt, imm};
            4'd4:  wdata_d = {6'h0f, 5'd0, rt, imm};
            4'd5:  wdata_d = {6'h23, rs, rt, imm};
            4'd6:  wdata_d = {6'h2b, rs, rt, imm};
            4'd7, 4'd8: begin
                wdata_d = {(op_sel == 4'd7) ? 6'h04 : 6'h05, rs, rt, br_off[15:0]};
                if (target[1:0] != 2'b00) begin
                    code_d = 2'd2;
                end else if (!br_in_range) begin
                    code_d = 2'd3;
                end
            end
            4'd9, 4'd10: begin
                wdata_d = {(op_sel == 4'd9) ? 6'h02 : 6'h03, target[27:2]};
                if (target[1:0] != 2'b00) begin
                    code_d = 2'd2;
                end else if (target[31:28] != pc_next4[31:28]) begin
                    code_d = 2'd3;
                end
            end
            default: code_d = 2'd1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= BASE_ADDR;
            count_q    <= '0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            full_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
        end else if (start) begin
            state_q    <= S_LOAD;
            pc_q       <= BASE_ADDR;
            count_q    <= '0;
            in_ready_q <= 1'b1;
            we_q       <= 1'b0;
            full_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        if (code_d != 2'd0) begin
                            state_q    <= S_ERROR;
                            err_q      <= 1'b1;
                            err_code_q <= code_d;
                        end else begin
                            state_q <= S_WRITE;
                            we_q    <= 1'b1;
                            addr_q  <= pc_q;
                            wdata_q <= wdata_d;
                        end
                    end
                end
                S_WRITE: begin
                    we_q    <= 1'b0;
                    pc_q    <= pc_next4;
                    count_q <= count_q + CNT_W'(1);
                    if ((count_q + CNT_W'(1)) == CNT_W'(DEPTH)) begin
                        state_q <= S_FULL;
                        full_q  <= 1'b1;
                    end else begin
                        state_q    <= S_LOAD;
                        in_ready_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign word_count = count_q;
    assign full       = full_q;
    assign err        = err_q;
    assign err_code   = err_code_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - directed self-checking bench for instr_encoder_loader
module tb_instr_encoder_loader;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       op_sel = 4'd0;
    logic [4:0]       rs = 5'd0;
    logic [4:0]       rt = 5'd0;
    logic [4:0]       rd = 5'd0;
    logic [4:0]       shamt = 5'd0;
    logic [5:0]       funct = 6'd0;
    logic [15:0]      imm = 16'd0;
    logic [31:0]      target = 32'd0;
    logic             imem_we;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_wdata;
    logic [CNT_W-1:0] word_count;
    logic             full;
    logic             err;
    logic [1:0]       err_code;

    int n_cmp = 0;
    int n_bad = 0;

    instr_encoder_loader #(
        .BASE_ADDR(32'h0040_0000),
        .DEPTH    (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sel    (op_sel),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .shamt     (shamt),
        .funct     (funct),
        .imm       (imm),
        .target    (target),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .word_count(word_count),
        .full      (full),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Returns #1 after the handshake edge, i.e. in the cycle that follows acceptance.
    task automatic send(input logic [3:0] op, input logic [4:0] rs_v, input logic [4:0] rt_v,
                        input logic [4:0] rd_v, input logic [4:0] sh_v, input logic [5:0] fn_v,
                        input logic [15:0] imm_v, input logic [31:0] tgt_v);
        int waited;
        op_sel = op; rs = rs_v; rt = rt_v; rd = rd_v; shamt = sh_v; funct = fn_v;
        imm = imm_v; target = tgt_v;
        in_valid = 1'b1;
        waited = 0;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (waited >= 20) check("handshake_timeout", 32'd0, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int n_we;

        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_we", imem_we, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_count", word_count, 0);
        check("rst_full", full, 0);
        check("rst_err", {err, err_code}, 0);
        reset = 1'b0;
        tick();
        check("idle_in_ready", in_ready, 0);

        pulse_start();
        check("start_in_ready", in_ready, 1);

        send(4'd0, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 16'd0, 32'd0);
        check("r_we", imem_we, 1);
        check("r_addr", imem_addr, 32'h0040_0000);
        check("r_wdata", imem_wdata, 32'h012A_4020);
        tick();
        check("r_we_drop", imem_we, 0);
        check("r_count", word_count, 1);

        send(4'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd5, 32'd0);
        check("addi_wdata", imem_wdata, 32'h2008_0005);
        check("addi_addr", imem_addr, 32'h0040_0004);
        check("addi_ready_low", in_ready, 0);
        tick();
        check("addi_ready_back", in_ready, 1);

        send(4'd7, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 32'h0040_0008);
        check("beq_back_wdata", imem_wdata, 32'h1000_FFFF);
        check("beq_back_addr", imem_addr, 32'h0040_0008);
        tick();

        send(4'd10, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 32'h0040_0000);
        check("jal_wdata", imem_wdata, 32'h0C10_0000);
        check("jal_addr", imem_addr, 32'h0040_000C);
        tick();
        check("full_flag", full, 1);
        check("full_count", word_count, 4);
        check("full_ready", in_ready, 0);

        in_valid = 1'b1;
        n_we = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (imem_we) n_we++;
        end
        in_valid = 1'b0;
        check("full_no_write", n_we, 0);
        check("full_count_hold", word_count, 4);

        pulse_start();
        send(4'd12, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 32'd0);
        check("illegal_err", {err, err_code}, {1'b1, 2'd1});
        check("illegal_we", imem_we, 0);
        check("illegal_ready", in_ready, 0);
        tick();
        check("error_hold", {err, err_code}, {1'b1, 2'd1});

        pulse_start();
        check("clear_err", {err, err_code}, 0);
        check("clear_ready", in_ready, 1);
        check("clear_count", word_count, 0);

        send(4'd4, 5'd5, 5'd3, 5'd0, 5'd0, 6'd0, 16'h1234, 32'd0);
        check("lui_wdata", imem_wdata, 32'h3C03_1234);
        tick();
        send(4'd7, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 32'h0042_0004);
        check("beq_max_off", imem_wdata, 32'h1000_7FFF);
        check("beq_max_err", err, 0);
        tick();

        send(4'd7, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 32'h0040_0002);
        check("beq_misaligned", {err, err_code}, {1'b1, 2'd2});
        check("beq_misaligned_we", imem_we, 0);

        pulse_start();
        send(4'd8, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 32'h0044_0000);
        check("bne_range", {err, err_code}, {1'b1, 2'd3});

        pulse_start();
        send(4'd8, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 32'h0044_0002);
        check("err_priority", err_code, 2);

        pulse_start();
        send(4'd9, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 32'h1000_0000);
        check("j_region", {err, err_code}, {1'b1, 2'd3});

        pulse_start();
        send(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'd0, 32'd0);
        check("pre_reset_we", imem_we, 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_we", imem_we, 0);
        check("async_reset_ready", in_ready, 0);
        #2;
        reset = 1'b0;
        tick();
        pulse_start();
        send(4'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd5, 32'd0);
        check("post_reset_addr", imem_addr, 32'h0040_0000);
        check("post_reset_we", imem_we, 1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Instruction encoder and program loader for the single-cycle MIPS core; it is the inverse of the opcode decode path. It accepts symbolic instruction requests over a valid/ready handshake and packs them into 32-bit MIPS words. Branch and jump targets are resolved to PC-relative or pseudo-direct fields. Each word is written sequentially into instruction memory starting at BASE_ADDR. It is used by the bench and boot path to build programs without an external assembler.

Parameters:
BASE_ADDR, 32'h0040_0000, byte address of the first word written.
DEPTH, 64, maximum number of words per load session.
CNT_W, $clog2(DEPTH)+1, width of word_count.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  one-cycle pulse; opens a new load session.
in_valid  input  1  request valid.
in_ready  output  1  encoder can accept a request.
op_sel  input  4  0=R,1=ADDI,2=ORI,3=ANDI,4=LUI,5=LW,6=SW,7=BEQ,8=BNE,9=J,10=JAL.
rs  input  5  source/base register.
rt  input  5  target register.
rd  input  5  destination register (R only).
shamt  input  5  shift amount (R only).
funct  input  6  function code (R only).
imm  input  16  immediate or load/store offset.
target  input  32  absolute byte address (BEQ/BNE/J/JAL).
imem_we  output  1  instruction-memory write strobe.
imem_addr  output  32  write byte address.
imem_wdata  output  32  encoded word.
word_count  output  CNT_W  words written in the current session.
full  output  1  word_count == DEPTH.
err  output  1  sticky error flag.
err_code  output  2  0=none, 1=illegal op_sel, 2=misaligned target, 3=target out of range.

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0; pc=BASE_ADDR.
- States and transitions:
  - IDLE: in_ready=0.
  - LOAD: in_ready=1. Handshake (in_valid&in_ready) with a legal request goes to WRITE; with an illegal request goes to ERROR.
  - WRITE: in_ready=0; imem_we=1 for exactly one cycle; imem_addr=pc, imem_wdata=registered word. At the end of the cycle pc+=4 and word_count+=1. Next state is FULL if word_count reaches DEPTH, else LOAD.
  - FULL: in_ready=0; full=1.
  - ERROR: in_ready=0; err and err_code held; nothing is written.
- start, in any state, has priority over in_valid:
  - sets pc=BASE_ADDR, word_count=0, err=0, err_code=0, full=0, imem_we=0;
  - next state is LOAD.
  - A start during WRITE aborts that write; imem_we drops the next cycle.
- Latency: request accepted in cycle N; write occurs in cycle N+1. Throughput is one word per 2 cycles.
- Encoding (registered at handshake):
  - R: {6'h00, rs, rt, rd, shamt, funct}.
  - ADDI 6'h08, ORI 6'h0d, ANDI 6'h0c, LW 6'h23, SW 6'h2b: {op, rs, rt, imm}.
  - LUI 6'h0f: {op, 5'd0, rt, imm}; rs is ignored.
  - BEQ 6'h04, BNE 6'h05: {op, rs, rt, off16}.
    - off = (target − (pc+4)) >>> 2, computed as 33-bit signed.
    - target[1:0]≠0 gives code 2.
    - off outside −32768..32767 gives code 3.
  - J 6'h02, JAL 6'h03: {op, target[27:2]}.
    - target[1:0]≠0 gives code 2.
    - target[31:28]≠(pc+4)[31:28] gives code 3.
  - op_sel 11..15 gives code 1.
- Error priority when several errors apply: 1 > 2 > 3.
- pc used for offset resolution is the address the word will occupy.
- in_valid while in_ready=0 is ignored; requesters must hold a request until it is accepted.

Test Plan:
- reset, start, R: rs=9 rt=10 rd=8 shamt=0 funct=0x20 -> in cycle N+1: imem_we=1, addr=0x00400000, wdata=0x012A4020; word_count=1.
- ADDI rs=0 rt=8 imm=5 -> wdata=0x20080005 at addr 0x00400004; in_ready low for exactly 1 cycle after handshake.
- BEQ rs=0 rt=0 target=0x00400008 at pc 0x00400008 -> wdata=0x1000FFFF. JAL target=0x00400000 at pc 0x0040000C -> wdata=0x0C100000.
- op_sel=12 -> err=1, err_code=1, no imem_we, in_ready=0. BEQ with target=0x00400002 after start -> err_code=2. Branch with target=pc+0x40000 -> err_code=3. start -> err=0 and state LOAD.
- DEPTH=4: four requests -> last write at 0x0040000C, full=1, word_count=4, in_ready=0. A fifth in_valid produces no write.
- reset asserted during WRITE -> imem_we=0 immediately (same cycle, asynchronous). After reset and start, the next write goes to 0x00400000.
